// File: rtl/iitk_mini_mips_core.sv
// iitk_mini_mips_core: single-cycle 32-bit Mini-MIPS processor.
// Holds the PC, instruction memory, 32x32 register file, data memory, decoder and ALU.
// Every instruction completes in one clock. Instruction memory is loaded externally
// through a hierarchical path.
// Ports:
//   clk   - clock; all state updates on the rising edge
//   reset - asynchronous active-low reset; clears pc and the register file
module iitk_mini_mips_core #(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 256
) (
    input  logic clk,
    input  logic reset
);

    localparam int unsigned IAW = $clog2(IMEM_DEPTH);
    localparam int unsigned DAW = $clog2(DMEM_DEPTH);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLA   = 6'b010100;
    localparam logic [5:0] OP_SRAI  = 6'b010101;
    localparam logic [5:0] OP_SRLI  = 6'b010110;
    localparam logic [5:0] OP_LW    = 6'b011101;
    localparam logic [5:0] OP_SW    = 6'b011110;
    localparam logic [5:0] OP_BEQ   = 6'b100000;
    localparam logic [5:0] OP_BNE   = 6'b100001;
    localparam logic [5:0] OP_J     = 6'b011000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;

    logic [31:0] instruction_memory [IMEM_DEPTH];
    logic [31:0] data_memory [DMEM_DEPTH];
    logic [31:0] reg_file [32];
    logic [31:0] pc;
    logic [31:0] pc_d;
    logic [31:0] instruction;

    // Decode flags, observable by hierarchical reference
    logic alu, mem, branch, jump, R, I, J;

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] rs_val, rt_val, imm_sext, imm_zext;

    logic           wb_en;
    logic [4:0]     wb_addr;
    logic [31:0]    wb_data;
    logic           dmem_we;
    logic [DAW-1:0] dmem_addr;

    // Fetch: pc is a word index, wrapped onto the instruction memory
    assign instruction = instruction_memory[IAW'(pc)];

    assign op     = instruction[31:26];
    assign rs     = instruction[25:21];
    assign rt     = instruction[20:16];
    assign rd     = instruction[15:11];
    assign shamt  = instruction[10:6];
    assign funct  = instruction[5:0];
    assign imm    = instruction[15:0];
    assign target = instruction[25:0];

    assign rs_val   = reg_file[rs];
    assign rt_val   = reg_file[rt];
    assign imm_sext = {{16{imm[15]}}, imm};
    assign imm_zext = {16'h0000, imm};

    // Load/store effective address, wrapped onto the data memory
    assign dmem_addr = DAW'(rs_val + imm_sext);

    // Decode, execute and next-pc selection
    always_comb begin
        alu     = 1'b0;
        mem     = 1'b0;
        branch  = 1'b0;
        jump    = 1'b0;
        R       = 1'b0;
        I       = 1'b0;
        J       = 1'b0;
        wb_en   = 1'b0;
        wb_addr = rt;
        wb_data = 32'h0;
        dmem_we = 1'b0;
        pc_d    = pc + 32'd1;

        case (op)
            OP_RTYPE: begin
                R       = 1'b1;
                alu     = 1'b1;
                wb_en   = 1'b1;
                wb_addr = rd;
                case (funct)
                    FN_ADD:  wb_data = rs_val + rt_val;
                    FN_SUB:  wb_data = rs_val - rt_val;
                    FN_AND:  wb_data = rs_val & rt_val;
                    FN_OR:   wb_data = rs_val | rt_val;
                    FN_XOR:  wb_data = rs_val ^ rt_val;
                    FN_SLT:  wb_data = {31'h0, $signed(rs_val) < $signed(rt_val)};
                    FN_SLL:  wb_data = rt_val << shamt;
                    FN_SRL:  wb_data = rt_val >> shamt;
                    FN_SRA:  wb_data = 32'($signed(rt_val) >>> shamt);
                    default: wb_en   = 1'b0;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLA, OP_SRAI, OP_SRLI: begin
                I     = 1'b1;
                alu   = 1'b1;
                wb_en = 1'b1;
                case (op)
                    OP_ADDI: wb_data = rs_val + imm_sext;
                    OP_ANDI: wb_data = rs_val & imm_zext;
                    OP_ORI:  wb_data = rs_val | imm_zext;
                    OP_XORI: wb_data = rs_val ^ imm_zext;
                    OP_SLTI: wb_data = {31'h0, $signed(rs_val) < $signed(imm_sext)};
                    OP_SLA:  wb_data = rs_val << imm[4:0];
                    OP_SRAI: wb_data = 32'($signed(rs_val) >>> imm[4:0]);
                    default: wb_data = rs_val >> imm[4:0];
                endcase
            end
            OP_LW: begin
                I       = 1'b1;
                mem     = 1'b1;
                wb_en   = 1'b1;
                wb_data = data_memory[dmem_addr];
            end
            OP_SW: begin
                I       = 1'b1;
                mem     = 1'b1;
                dmem_we = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                I      = 1'b1;
                branch = 1'b1;
                if ((rs_val == rt_val) == (op == OP_BEQ)) begin
                    pc_d = pc + 32'd1 + imm_sext;
                end
            end
            OP_J: begin
                J    = 1'b1;
                jump = 1'b1;
                pc_d = {6'h00, target};
            end
            default: ;
        endcase
    end

    // Program counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= 32'h0;
        end else begin
            pc <= pc_d;
        end
    end

    // Register file; R0 is an ordinary writable register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                reg_file[i] <= 32'h0;
            end
        end else if (wb_en) begin
            reg_file[wb_addr] <= wb_data;
        end
    end

    // Data memory is not cleared by reset, but a store is blocked while reset is low
    always_ff @(posedge clk) begin
        if (reset && dmem_we) begin
            data_memory[dmem_addr] <= rt_val;
        end
    end

endmodule

// File: tb/tb_iitk_mini_mips_core.sv
// Directed bench for iitk_mini_mips_core: programs are loaded into instruction memory
// hierarchically, operands are preloaded into the register file/data memory, and
// architectural state is checked 1 time unit after each rising edge.
module tb_iitk_mini_mips_core;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    localparam logic [31:0] NOP = 32'hFC00_0000;

    // Flag vector order: {R, I, J, alu, mem, branch, jump}
    localparam logic [31:0] F_RALU = 32'h48;
    localparam logic [31:0] F_IALU = 32'h28;
    localparam logic [31:0] F_JMP  = 32'h11;
    localparam logic [31:0] F_MEM  = 32'h24;
    localparam logic [31:0] F_BR   = 32'h22;
    localparam logic [31:0] F_NONE = 32'h00;

    always #5 clk = ~clk;

    iitk_mini_mips_core #(.IMEM_DEPTH(256), .DMEM_DEPTH(256)) dut (
        .clk   (clk),
        .reset (reset)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] flags_now();
        return {25'h0, dut.R, dut.I, dut.J, dut.alu, dut.mem, dut.branch, dut.jump};
    endfunction

    task automatic hold_reset_and_clear();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 256; i++) dut.instruction_memory[i] = NOP;
    endtask

    // Release away from any clock edge
    task automatic release_reset();
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_branch(input string tag, input logic [31:0] instr,
                              input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] exp_pc);
        hold_reset_and_clear();
        dut.instruction_memory[4] = instr;
        release_reset();
        dut.reg_file[1] = a;
        dut.reg_file[2] = b;
        repeat (4) step();
        chk({tag, "_pc_before"}, dut.pc, 32'd4);
        chk({tag, "_flags"}, flags_now(), F_BR);
        step();
        chk({tag, "_pc_after"}, dut.pc, exp_pc);
    endtask

    logic [31:0] alu_prog [14];
    int          alu_dst  [14];
    logic [31:0] alu_exp  [14];

    initial begin
        alu_prog = '{32'h0022_1822, 32'h0061_202A, 32'h0003_2843, 32'h0003_3102,
                     32'h2007_FFFF, 32'h38E8_00FF, 32'h2869_FFFF, 32'h546A_0001,
                     32'h586B_0001, 32'h0022_183F, 32'h0021_0820, 32'h30EC_8001,
                     32'h0022_6824, 32'h0002_7100};
        alu_dst  = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 3, 1, 12, 13, 14};
        alu_exp  = '{32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0FFF_FFFF,
                     32'hFFFF_FFFF, 32'hFFFF_FF00, 32'h0000_0001, 32'hFFFF_FFFF,
                     32'h7FFF_FFFF, 32'hFFFF_FFFE, 32'h0000_000A, 32'h0000_8001,
                     32'h0000_0002, 32'h0000_0070};

        // add / sla / jump-to-self
        hold_reset_and_clear();
        dut.instruction_memory[0] = 32'h0022_0020;
        dut.instruction_memory[1] = 32'h5042_0002;
        dut.instruction_memory[2] = 32'h6000_0002;
        dut.instruction_memory[3] = 32'h0000_0020;
        release_reset();
        chk("reset_pc", dut.pc, 32'd0);
        chk("reset_r1", dut.reg_file[1], 32'd0);
        dut.reg_file[1] = 32'd5;
        dut.reg_file[2] = 32'd7;
        chk("add_flags", flags_now(), F_RALU);
        step();
        chk("add_r0", dut.reg_file[0], 32'd12);
        chk("add_pc", dut.pc, 32'd1);
        chk("sla_flags", flags_now(), F_IALU);
        dut.reg_file[2] = 32'd3;
        step();
        chk("sla_r2", dut.reg_file[2], 32'd12);
        chk("sla_pc", dut.pc, 32'd2);
        chk("j_flags", flags_now(), F_JMP);
        step();
        chk("j_pc_1", dut.pc, 32'd2);
        step();
        chk("j_pc_2", dut.pc, 32'd2);
        chk("j_skip_r0", dut.reg_file[0], 32'd12);

        // lw / sw / undefined opcode / beq not taken
        hold_reset_and_clear();
        dut.instruction_memory[0] = 32'h7422_0004;
        dut.instruction_memory[1] = 32'h7822_0004;
        dut.instruction_memory[4] = 32'h8022_0003;
        release_reset();
        dut.reg_file[1] = 32'd10;
        dut.data_memory[14] = 32'hDEAD_BEEF;
        chk("lw_flags", flags_now(), F_MEM);
        step();
        chk("lw_r2", dut.reg_file[2], 32'hDEAD_BEEF);
        chk("lw_pc", dut.pc, 32'd1);
        chk("sw_flags", flags_now(), F_MEM);
        dut.reg_file[2] = 32'h55;
        step();
        chk("sw_dmem", dut.data_memory[14], 32'h55);
        chk("nop_flags", flags_now(), F_NONE);
        step();
        chk("nop_pc", dut.pc, 32'd3);
        chk("nop_r2", dut.reg_file[2], 32'h55);
        chk("nop_dmem", dut.data_memory[14], 32'h55);
        step();
        chk("beq_ne_flags", flags_now(), F_BR);
        step();
        chk("beq_ne_pc", dut.pc, 32'd5);

        run_branch("beq_eq", 32'h8022_0003, 32'd9, 32'd9, 32'd8);
        run_branch("bne_eq", 32'h8422_0003, 32'd9, 32'd9, 32'd5);
        run_branch("bne_ne", 32'h8422_0003, 32'd1, 32'd2, 32'd8);

        // ALU coverage, including unknown funct and rd==rs
        hold_reset_and_clear();
        for (int i = 0; i < 14; i++) dut.instruction_memory[i] = alu_prog[i];
        release_reset();
        dut.reg_file[1] = 32'd5;
        dut.reg_file[2] = 32'd7;
        for (int i = 0; i < 14; i++) begin
            step();
            chk($sformatf("alu_%0d_r%0d", i, alu_dst[i]), dut.reg_file[alu_dst[i]], alu_exp[i]);
        end
        chk("alu_pc", dut.pc, 32'd14);

        // Asynchronous reset mid-cycle, and store suppression while held
        #3 reset = 1'b0;
        #1;
        chk("async_pc", dut.pc, 32'd0);
        for (int r = 0; r < 32; r++) chk($sformatf("async_r%0d", r), dut.reg_file[r], 32'd0);
        dut.instruction_memory[0] = 32'h7822_0004;
        dut.data_memory[4] = 32'h1234;
        step();
        chk("rst_hold_dmem", dut.data_memory[4], 32'h1234);
        chk("rst_hold_pc", dut.pc, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
